sd2_ovf_seq: RTL

- Digit-serial sequencer for the SD2 overflow-correction datapath.
- Accepts one DIGITS-digit SD2 word and walks adjacent digit pairs MSD-first through the combinational overflow cell, one pair per cycle.
- Assembles the corrected result word, captures the sign digit and a sticky error flag, then returns the result over a valid/ready handshake.
- Sits between the divider's operand buffer and its result stage; the overflow cell is instantiated externally and connected via the ovf_* ports.

---
 rtl/sd2_ovf_seq.sv | 110 +++++++++++
 1 files changed

// File: rtl/sd2_ovf_seq.sv
// sd2_ovf_seq: digit-serial sequencer that walks SD2 digit pairs MSD-first through an
// external overflow cell and returns the corrected word over a valid/ready handshake.
module sd2_ovf_seq #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DIGITS-1:0]   in_word,
    input  logic                  tr_in,
    output logic [1:0]            ovf_minm,
    output logic [1:0]            ovf_minl,
    output logic                  ovf_tr,
    input  logic [1:0]            ovf_res,
    input  logic [1:0]            ovf_sign,
    input  logic                  ovf_wrong,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DIGITS-1:0]   out_word,
    output logic [1:0]            out_sign,
    output logic                  out_err,
    output logic                  busy
);
    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [DIGITS-1:0][1:0] word_q, word_d, res_q, res_d, out_word_q, out_word_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   tr_q, tr_d, out_err_q, out_err_d, done_en;
    logic [1:0]             sign_q, sign_d, out_sign_q, out_sign_d;

    function automatic logic [1:0] canon(input logic [1:0] d);
        return (d == 2'b10) ? 2'b01 : d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            res_q      <= '0;
            out_word_q <= '0;
            idx_q      <= '0;
            tr_q       <= 1'b0;
            sign_q     <= 2'b00;
            out_sign_q <= 2'b00;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            res_q      <= res_d;
            out_word_q <= out_word_d;
            idx_q      <= idx_d;
            tr_q       <= tr_d;
            sign_q     <= sign_d;
            out_sign_q <= out_sign_d;
            out_err_q  <= out_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        res_d   = res_q;
        idx_d   = idx_q;
        tr_d    = tr_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: if (in_valid) begin
                word_d  = in_word;
                tr_d    = tr_in;
                idx_d   = IW'(DIGITS - 1);
                res_d   = '0;
                sign_d  = 2'b00;
                state_d = RUN;
            end
            RUN: begin
                res_d[idx_q] = ovf_wrong ? 2'b00 : canon(ovf_res);
                if (idx_q == IW'(DIGITS - 1) && !ovf_wrong)
                    sign_d = ovf_sign;
                if (ovf_wrong)
                    state_d = DONE;
                else if (idx_q == IW'(1)) begin
                    res_d[0] = canon(word_q[0]);
                    state_d  = DONE;
                end else
                    idx_d = idx_q - IW'(1);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Visible result registers change only on DONE entry so the last result survives IDLE/RUN.
        done_en    = (state_q == RUN) && (state_d == DONE);
        out_word_d = done_en ? res_d : out_word_q;
        out_sign_d = done_en ? sign_d : out_sign_q;
        out_err_d  = done_en ? ovf_wrong : out_err_q;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign ovf_minm  = (state_q == RUN) ? word_q[idx_q] : 2'b00;
    assign ovf_minl  = (state_q == RUN) ? word_q[idx_q - IW'(1)] : 2'b00;
    assign ovf_tr    = (state_q == RUN) && tr_q;
    assign out_word  = out_word_q;
    assign out_sign  = out_sign_q;
    assign out_err   = out_err_q;
endmodule
